// File: rtl/process_data_udiv_32ns_4ns_32_seq_if.sv
// ----------------------------------------------------------------------------
// process_data_udiv_32ns_4ns_32_seq_if
// Request/response bundle for the sequential unsigned divider.
//   master : drives ce, start, din0, din1; observes busy, done, quot, rem, dbz
//   slave  : the divider side of the same signals
// ----------------------------------------------------------------------------
interface process_data_udiv_32ns_4ns_32_seq_if #(
    parameter int DIN0_W = 32,
    parameter int DIN1_W = 4,
    parameter int DOUT_W = 32
);
    logic              ce;
    logic              start;
    logic [DIN0_W-1:0] din0;
    logic [DIN1_W-1:0] din1;
    logic              busy;
    logic              done;
    logic [DOUT_W-1:0] quot;
    logic [DIN1_W-1:0] rem;
    logic              dbz;

    modport master (
        output ce, start, din0, din1,
        input  busy, done, quot, rem, dbz
    );

    modport slave (
        input  ce, start, din0, din1,
        output busy, done, quot, rem, dbz
    );
endinterface

// File: rtl/process_data_udiv_32ns_4ns_32_seq.sv
// ----------------------------------------------------------------------------
// process_data_udiv_32ns_4ns_32_seq
// Radix-2 restoring unsigned divider, one quotient bit per enabled clock.
// Ports:
//   ap_clk  : clock, rising edge
//   ap_rst  : synchronous active-high reset (wins over ce)
//   bus     : slave side of the request/response interface
//             ce (global stall), start/din0/din1 (request),
//             busy/done/quot/rem/dbz (status and registered result)
// ----------------------------------------------------------------------------
module process_data_udiv_32ns_4ns_32_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 4,
    parameter int dout_WIDTH = 32
) (
    input  logic ap_clk,
    input  logic ap_rst,
    process_data_udiv_32ns_4ns_32_seq_if.slave bus
);
    localparam int W0    = din0_WIDTH;
    localparam int W1    = din1_WIDTH;
    localparam int CNT_W = $clog2(din0_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [W0-1:0]    dvd_q, dvd_d;     // dividend shifts out MSB, quotient shifts in LSB
    logic [W1-1:0]    dvs_q, dvs_d;
    logic [W1:0]      r_q, r_d;         // one extra bit holds the shifted partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W0-1:0]    quot_q, quot_d;
    logic [W1-1:0]    rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Single restoring step on the current registers.
    logic [W1:0]   r_sh, r_nx;
    logic          ge;
    logic [W0-1:0] q_nx;
    logic          dz;

    always_comb begin
        r_sh = {r_q[W1-1:0], dvd_q[W0-1]};
        ge   = (r_sh >= {1'b0, dvs_q});
        r_nx = ge ? (r_sh - {1'b0, dvs_q}) : r_sh;
        q_nx = {dvd_q[W0-2:0], ge};
        dz   = (dvs_q == '0);
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        if (bus.ce) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // A new request beats the DONE->IDLE fall-through.
                    if (bus.start) begin
                        dvd_d   = bus.din0;
                        dvs_d   = bus.din1;
                        r_d     = '0;
                        cnt_d   = CNT_W'(W0);
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    r_d   = r_nx;
                    dvd_d = q_nx;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        // Zero divisor runs the full latency; result forced here.
                        quot_d  = dz ? '1 : q_nx;
                        rem_d   = dz ? '0 : r_nx[W1-1:0];
                        dbz_d   = dz;
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.quot = dout_WIDTH'(quot_q);
    assign bus.rem  = rem_q;
    assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_process_data_udiv_32ns_4ns_32_seq.sv
module tb_process_data_udiv_32ns_4ns_32_seq;
    logic ap_clk = 1'b0;
    logic ap_rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 ap_clk = ~ap_clk;

    process_data_udiv_32ns_4ns_32_seq_if #(.DIN0_W(32), .DIN1_W(4), .DOUT_W(32)) bus ();

    process_data_udiv_32ns_4ns_32_seq #(
        .ID(1), .din0_WIDTH(32), .din1_WIDTH(4), .dout_WIDTH(32)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request at a negedge and step past the accept edge;
    // operands are scrambled afterwards to prove they were captured.
    task automatic start_op(input logic [31:0] a, input logic [3:0] b);
        bus.start = 1'b1;
        bus.din0  = a;
        bus.din1  = b;
        @(negedge ap_clk);
        bus.start = 1'b0;
        bus.din0  = $urandom;
        bus.din1  = 4'($urandom);
    endtask

    // Counts negedges until done is seen; flags busy&done overlap.
    task automatic wait_done(input string tag, output int lat, output int bc);
        int both = 0;
        lat = 0;
        bc  = 0;
        while (!bus.done && lat < 200) begin
            if (bus.busy) bc++;
            @(negedge ap_clk);
            lat++;
            if (bus.busy && bus.done) both++;
        end
        chk({tag, "_timeout"}, 64'(lat < 200), 64'd1);
        chk({tag, "_busy_and_done"}, 64'(both), 64'd0);
    endtask

    initial begin
        int lat, bc, dcnt;
        logic [31:0] a;
        logic [3:0]  b;

        ap_rst    = 1'b1;
        bus.ce    = 1'b1;
        bus.start = 1'b0;
        bus.din0  = '0;
        bus.din1  = '0;
        repeat (2) @(negedge ap_clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_quot", 64'(bus.quot), 64'd0);
        chk("rst_rem",  64'(bus.rem),  64'd0);
        chk("rst_dbz",  64'(bus.dbz),  64'd0);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // 100 / 7
        start_op(32'd100, 4'd7);
        wait_done("d100", lat, bc);
        chk("d100_lat",  64'(lat), 64'd32);
        chk("d100_busy", 64'(bc),  64'd32);
        chk("d100_quot", 64'(bus.quot), 64'd14);
        chk("d100_rem",  64'(bus.rem),  64'd2);
        chk("d100_dbz",  64'(bus.dbz),  64'd0);
        @(negedge ap_clk);
        chk("d100_done_fall", 64'(bus.done), 64'd0);
        chk("d100_hold_quot", 64'(bus.quot), 64'd14);

        // All-ones dividend
        start_op(32'hFFFF_FFFF, 4'd15);
        wait_done("ff15", lat, bc);
        chk("ff15_quot", 64'(bus.quot), 64'h1111_1111);
        chk("ff15_rem",  64'(bus.rem),  64'd0);
        @(negedge ap_clk);
        start_op(32'hFFFF_FFFF, 4'd1);
        wait_done("ff1", lat, bc);
        chk("ff1_quot", 64'(bus.quot), 64'hFFFF_FFFF);
        chk("ff1_rem",  64'(bus.rem),  64'd0);
        @(negedge ap_clk);

        // Divide by zero, then a normal op clears dbz
        start_op(32'h1234_5678, 4'd0);
        wait_done("dz", lat, bc);
        chk("dz_lat",  64'(lat), 64'd32);
        chk("dz_quot", 64'(bus.quot), 64'hFFFF_FFFF);
        chk("dz_rem",  64'(bus.rem),  64'd0);
        chk("dz_dbz",  64'(bus.dbz),  64'd1);
        @(negedge ap_clk);
        start_op(32'd9, 4'd4);
        wait_done("d9", lat, bc);
        chk("d9_quot", 64'(bus.quot), 64'd2);
        chk("d9_rem",  64'(bus.rem),  64'd1);
        chk("d9_dbz",  64'(bus.dbz),  64'd0);
        // ce low during DONE holds the pulse
        bus.ce = 1'b0;
        @(negedge ap_clk);
        chk("ce_hold_done", 64'(bus.done), 64'd1);
        bus.ce = 1'b1;
        @(negedge ap_clk);
        chk("ce_hold_fall", 64'(bus.done), 64'd0);

        // start during RUN is ignored
        start_op(32'd1000, 4'd9);
        repeat (5) @(negedge ap_clk);
        bus.start = 1'b1;
        bus.din0  = 32'd50;
        bus.din1  = 4'd3;
        @(negedge ap_clk);
        bus.start = 1'b0;
        wait_done("ign", lat, bc);
        chk("ign_lat",  64'(lat + 6), 64'd32);
        chk("ign_quot", 64'(bus.quot), 64'd111);
        chk("ign_rem",  64'(bus.rem),  64'd1);
        dcnt = 0;
        repeat (5) begin
            @(negedge ap_clk);
            if (bus.done || bus.busy) dcnt++;
        end
        chk("ign_single_done", 64'(dcnt), 64'd0);

        // Back-to-back: accept while in DONE
        start_op(32'd1000, 4'd9);
        wait_done("b2b1", lat, bc);
        chk("b2b1_quot", 64'(bus.quot), 64'd111);
        start_op(32'd50, 4'd3);
        chk("b2b_no_idle", 64'(bus.busy), 64'd1);
        wait_done("b2b2", lat, bc);
        chk("b2b2_lat",  64'(lat), 64'd32);
        chk("b2b2_quot", 64'(bus.quot), 64'd16);
        chk("b2b2_rem",  64'(bus.rem),  64'd2);
        @(negedge ap_clk);

        // ce stall of 7 cycles mid-RUN
        start_op(32'd1000, 4'd9);
        repeat (10) @(negedge ap_clk);
        bus.ce = 1'b0;
        repeat (7) @(negedge ap_clk);
        chk("stall_busy", 64'(bus.busy), 64'd1);
        bus.ce = 1'b1;
        wait_done("stall", lat, bc);
        chk("stall_lat",  64'(lat + 17), 64'd39);
        chk("stall_quot", 64'(bus.quot), 64'd111);
        chk("stall_rem",  64'(bus.rem),  64'd1);
        @(negedge ap_clk);

        // Reset mid-RUN
        start_op(32'd777, 4'd5);
        repeat (10) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_done", 64'(bus.done), 64'd0);
        chk("mrst_quot", 64'(bus.quot), 64'd0);
        chk("mrst_rem",  64'(bus.rem),  64'd0);
        chk("mrst_dbz",  64'(bus.dbz),  64'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge ap_clk);
            if (bus.done) dcnt++;
        end
        chk("mrst_no_done", 64'(dcnt), 64'd0);
        start_op(32'd200, 4'd13);
        wait_done("d200", lat, bc);
        chk("d200_quot", 64'(bus.quot), 64'd15);
        chk("d200_rem",  64'(bus.rem),  64'd5);
        @(negedge ap_clk);

        // Random operands against the division invariant
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = 4'($urandom_range(1, 15));
            start_op(a, b);
            wait_done("rnd", lat, bc);
            chk("rnd_inv", 64'(bus.quot) * 64'(b) + 64'(bus.rem), 64'(a));
            chk("rnd_rem_lt", 64'(bus.rem < b), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
